// File: rtl/mult_gpio_bridge_pkg.sv
// mult_bridge_pkg
// Shared definitions for the GPIO-to-multiplier bridge:
//   - FSM state encoding, which software reads back in state_reg[1:0]
//   - bit positions of the status word (state_reg)
//   - bit positions of the command word (ctrl_reg)
//   - field ranges of the chunk index word (in_loc)
package mult_bridge_pkg;

   localparam int CHUNK_W = 32;

   // State codes are visible to software, so the encoding is fixed
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } bridge_state_e;

   // state_reg bit positions
   localparam int SR_DONE_BIT    = 2;
   localparam int SR_ERR_BIT     = 3;
   localparam int SR_TIMEOUT_BIT = 4;

   // ctrl_reg bit positions
   localparam int CTRL_LOAD_BIT  = 0;
   localparam int CTRL_START_BIT = 1;
   localparam int CTRL_CLEAR_BIT = 2;

   // in_loc fields: write index (bit 2 selects operand B), read index
   localparam int WR_IDX_LSB = 0;
   localparam int WR_IDX_MSB = 2;
   localparam int RD_IDX_LSB = 16;
   localparam int RD_IDX_MSB = 18;

endpackage

// File: rtl/mult_gpio_bridge_if.sv
// mult_gpio_bridge_if
// Handshake between the bridge and the 128-bit multiplier core.
//   op_a, op_b   operands presented to the core
//   core_start   one-cycle start pulse
//   core_done    completion pulse; core_result is valid in the same cycle
//   core_result  2*OP_W-bit product
// Modports: master = bridge side, slave = core side.
interface mult_gpio_bridge_if #(
   parameter int OP_W = 128
);

   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic              core_start;
   logic              core_done;
   logic [2*OP_W-1:0] core_result;

   modport master (
      output op_a,
      output op_b,
      output core_start,
      input  core_done,
      input  core_result
   );

   modport slave (
      input  op_a,
      input  op_b,
      input  core_start,
      output core_done,
      output core_result
   );

endinterface

// File: rtl/mult_gpio_bridge_rise_detect.sv
// rise_detect
// Previous-value register plus rising-edge flag for a W-bit vector.
//   clk, reset  clock, asynchronous active-low reset
//   sig         level inputs
//   rise        sig & ~previous sig, combinational from the current input
module rise_detect #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sig,
   output logic [W-1:0] rise
);

   logic [W-1:0] prev;

   // Remember last cycle's level so a held bit only fires once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev <= '0;
      end else begin
         prev <= sig;
      end
   end

   assign rise = sig & ~prev;

endmodule

// File: rtl/mult_gpio_bridge.sv
// mult_gpio_bridge
// Register-level bridge between MicroBlaze MCS GPIO channels and the
// multiplier core. Software writes operand chunks, pulses START, and reads
// the captured product back one 32-bit chunk at a time.
// Ports:
//   clk, reset  system clock, asynchronous active-low reset
//   in_loc      [2:0] write chunk index (4-7 = operand B), [18:16] read index
//   in_val      write data chunk
//   ctrl_reg    [0] LOAD, [1] START, [2] CLEAR, each acting on its rising edge
//   out_val     registered product chunk selected by in_loc[18:16]
//   state_reg   [1:0] state, [2] DONE, [3] ERR, [4] TIMEOUT
//   core        master side of mult_gpio_bridge_if
// Optional feature: define MULT_BRIDGE_TIMEOUT_EN to build the WAIT watchdog,
// which abandons a transaction after TIMEOUT_CYC cycles with a zero result.
module mult_gpio_bridge
   import mult_bridge_pkg::*;
#(
   parameter int OP_W        = 128,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CHUNK_W-1:0] in_loc,
   input  logic [CHUNK_W-1:0] in_val,
   input  logic [CHUNK_W-1:0] ctrl_reg,
   output logic [CHUNK_W-1:0] out_val,
   output logic [CHUNK_W-1:0] state_reg,
   mult_gpio_bridge_if.master core
);

   bridge_state_e     state;
   logic [OP_W-1:0]   op_a_q;
   logic [OP_W-1:0]   op_b_q;
   logic [2*OP_W-1:0] result_q;
   logic              core_start_q;
   logic              done_q;
   logic              err_q;
   logic              timeout_q;

   logic [CTRL_CLEAR_BIT:0] ctrl_rise;
   logic                    load_rise;
   logic                    start_rise;
   logic                    clear_rise;
   logic [2:0]              wr_idx;
   logic [2:0]              rd_idx;
   logic                    unused_inputs;

   rise_detect #(
      .W (CTRL_CLEAR_BIT + 1)
   ) u_ctrl_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (ctrl_reg[CTRL_CLEAR_BIT:0]),
      .rise  (ctrl_rise)
   );

   assign load_rise  = ctrl_rise[CTRL_LOAD_BIT];
   assign start_rise = ctrl_rise[CTRL_START_BIT];
   assign clear_rise = ctrl_rise[CTRL_CLEAR_BIT];
   assign wr_idx     = in_loc[WR_IDX_MSB:WR_IDX_LSB];
   assign rd_idx     = in_loc[RD_IDX_MSB:RD_IDX_LSB];

   assign unused_inputs = ^{in_loc[CHUNK_W-1:RD_IDX_MSB+1],
                            in_loc[RD_IDX_LSB-1:WR_IDX_MSB+1],
                            ctrl_reg[CHUNK_W-1:CTRL_CLEAR_BIT+1]};

`ifdef MULT_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] wait_cnt;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_CYC[0];
   assign timeout_q          = 1'b0;
`endif

   // Main FSM. CLEAR overrides everything else in the same cycle, including
   // a coincident core_done. LOAD and START together in IDLE/DONE write the
   // chunk on the same edge that enters START, so the core sees new data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         result_q     <= '0;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         out_val      <= '0;
`ifdef MULT_BRIDGE_TIMEOUT_EN
         timeout_q    <= 1'b0;
         wait_cnt     <= '0;
`endif
      end else begin
         core_start_q <= 1'b0;
         out_val      <= result_q[{rd_idx, 5'b0} +: CHUNK_W];

         if (clear_rise) begin
            state    <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MULT_BRIDGE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (load_rise) begin
                     if (wr_idx[2]) begin
                        op_b_q[{wr_idx[1:0], 5'b0} +: CHUNK_W] <= in_val;
                     end else begin
                        op_a_q[{wr_idx[1:0], 5'b0} +: CHUNK_W] <= in_val;
                     end
                  end
                  if (start_rise) begin
                     state        <= ST_START;
                     core_start_q <= 1'b1;
                     done_q       <= 1'b0;
                  end
               end
               ST_START: begin
                  if (load_rise || start_rise) begin
                     err_q <= 1'b1;
                  end
                  state <= ST_WAIT;
`ifdef MULT_BRIDGE_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
               ST_WAIT: begin
                  if (load_rise || start_rise) begin
                     err_q <= 1'b1;
                  end
                  if (core.core_done) begin
                     result_q <= core.core_result;
                     done_q   <= 1'b1;
                     state    <= ST_DONE;
                  end
`ifdef MULT_BRIDGE_TIMEOUT_EN
                  else if (wait_cnt == CNT_LAST) begin
                     result_q  <= '0;
                     done_q    <= 1'b1;
                     timeout_q <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     wait_cnt <= wait_cnt + CNT_W'(1);
                  end
`endif
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Status word is a direct view of the flops above
   always_comb begin
      state_reg                 = '0;
      state_reg[1:0]            = state;
      state_reg[SR_DONE_BIT]    = done_q;
      state_reg[SR_ERR_BIT]     = err_q;
      state_reg[SR_TIMEOUT_BIT] = timeout_q;
   end

   assign core.op_a       = op_a_q;
   assign core.op_b       = op_b_q;
   assign core.core_start = core_start_q;

endmodule
